// File: rtl/booth_share_arbiter.sv
// Round-robin arbiter sharing one sequential signed Booth multiplier core between two requesters.
// Optional abort-on-timeout in ARM/WAIT is enabled by defining BOOTH_ARB_TIMEOUT_EN.
module booth_share_arbiter #(
  parameter int N       = 8,
  parameter int TIMEOUT = 32
) (
  input  logic           Clock,
  input  logic           Reset_n,
  input  logic [1:0]     req,
  input  logic [N-1:0]   mplier0,
  input  logic [N-1:0]   mplier1,
  input  logic [N-1:0]   mpcand0,
  input  logic [N-1:0]   mpcand1,
  output logic [1:0]     gnt,
  output logic [1:0]     done,
  output logic [2*N-1:0] product0,
  output logic [2*N-1:0] product1,
  output logic           busy,
  output logic           core_start,
  output logic [N-1:0]   core_mplier,
  output logic [N-1:0]   core_mpcand,
  input  logic           core_done,
  input  logic [2*N-1:0] core_product,
  output logic           err
);

  typedef enum logic [2:0] {IDLE, LAUNCH, ARM, WAIT, DELIVER} state_t;

  state_t state, next;
  logic   ptr;
  logic   winner;
  logic   abort;

  // A sole requester always wins; on contention the pointer decides.
  always_comb begin
    winner = ptr;
    if (req == 2'b01)
      winner = 1'b0;
    else if (req == 2'b10)
      winner = 1'b1;
  end

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] tcnt;
  logic          tout;

  assign tout  = (tcnt == CW'(TIMEOUT - 1));
  assign abort = tout && ((state == ARM && core_done) || (state == WAIT && !core_done));

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      if (state == LAUNCH)
        tcnt <= '0;
      else if (state == ARM || state == WAIT)
        tcnt <= tcnt + CW'(1);
      if (abort)
        err <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT > 0);
  assign abort          = 1'b0;
  assign err            = 1'b0;
`endif

  always_comb begin
    next       = state;
    core_start = 1'b0;
    done       = 2'b00;
    case (state)
      IDLE:    if (req != 2'b00) next = LAUNCH;
      LAUNCH: begin
        core_start = 1'b1;
        next       = ARM;
      end
      // ARM waits for the core to drop the Done left over from the previous job.
      ARM: begin
        if (abort)
          next = DELIVER;
        else if (!core_done)
          next = WAIT;
      end
      WAIT:    if (core_done || abort) next = DELIVER;
      DELIVER: begin
        done = gnt;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_comb begin
    core_mplier = '0;
    core_mpcand = '0;
    if (gnt[0]) begin
      core_mplier = mplier0;
      core_mpcand = mpcand0;
    end else if (gnt[1]) begin
      core_mplier = mplier1;
      core_mpcand = mpcand1;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      gnt      <= 2'b00;
      ptr      <= 1'b0;
      product0 <= '0;
      product1 <= '0;
    end else begin
      state <= next;
      case (state)
        IDLE: if (req != 2'b00) gnt <= winner ? 2'b10 : 2'b01;
        WAIT: begin
          if (core_done) begin
            if (gnt[1])
              product1 <= core_product;
            else
              product0 <= core_product;
          end
        end
        DELIVER: begin
          ptr <= ~gnt[1];
          gnt <= 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_share_arbiter.sv
// Directed bench for booth_share_arbiter with a behavioural Booth core stand-in.
// The timeout scenario is exercised only when BOOTH_ARB_TIMEOUT_EN is defined.
module tb_booth_share_arbiter;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [1:0]  req;
  logic [7:0]  mplier0, mplier1, mpcand0, mpcand1;
  logic [1:0]  gnt, done;
  logic [15:0] product0, product1;
  logic        busy, core_start;
  logic [7:0]  core_mplier, core_mpcand;
  logic        core_done;
  logic [15:0] core_product;
  logic        err;

  int errors = 0;
  int checks = 0;
  int startCount = 0;
  int done0Count = 0;
  int done1Count = 0;

  // Core stand-in: Done may linger stickyHold cycles after a load, then rises coreLatency cycles later.
  int          stickyHold  = 0;
  int          coreLatency = 3;
  logic        stuckCore   = 1'b0;
  int          holdCnt, busyCnt;
  logic        running;
  logic [7:0]  opA, opB;

  booth_share_arbiter #(.N(8), .TIMEOUT(32)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .req(req),
    .mplier0(mplier0), .mplier1(mplier1), .mpcand0(mpcand0), .mpcand1(mpcand1),
    .gnt(gnt), .done(done), .product0(product0), .product1(product1),
    .busy(busy), .core_start(core_start), .core_mplier(core_mplier), .core_mpcand(core_mpcand),
    .core_done(core_done), .core_product(core_product), .err(err)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      core_done    <= 1'b0;
      core_product <= '0;
      running      <= 1'b0;
      holdCnt      <= 0;
      busyCnt      <= 0;
      opA          <= '0;
      opB          <= '0;
    end else if (core_start) begin
      opA     <= core_mplier;
      opB     <= core_mpcand;
      holdCnt <= stickyHold;
      busyCnt <= coreLatency;
      running <= 1'b1;
      if (stickyHold == 0)
        core_done <= 1'b0;
    end else if (running) begin
      if (holdCnt > 0) begin
        holdCnt <= holdCnt - 1;
        if (holdCnt == 1)
          core_done <= 1'b0;
      end else if (busyCnt > 0) begin
        busyCnt <= busyCnt - 1;
      end else if (!stuckCore) begin
        core_done    <= 1'b1;
        core_product <= $signed({{8{opA[7]}}, opA}) * $signed({{8{opB[7]}}, opB});
        running      <= 1'b0;
      end
    end
  end

  always @(negedge Clock) begin
    if (core_start) startCount++;
    if (done[0]) done0Count++;
    if (done[1]) done1Count++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [1:0] r, input logic [7:0] a0, input logic [7:0] b0,
                               input logic [7:0] a1, input logic [7:0] b1);
    req     = r;
    mplier0 = a0;
    mpcand0 = b0;
    mplier1 = a1;
    mpcand1 = b1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitStart(input string tag, input logic [7:0] expA, input logic [7:0] expB);
    int n = 0;
    while (core_start !== 1'b1 && n < 20) begin
      @(negedge Clock);
      n++;
    end
    checkOutput({tag, "_start"}, 32'(core_start), 32'd1);
    checkOutput({tag, "_mplier"}, 32'(core_mplier), 32'(expA));
    checkOutput({tag, "_mpcand"}, 32'(core_mpcand), 32'(expB));
  endtask

  task automatic waitDone(input int maxCycles, output int idx);
    int n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (done == 2'b00 && n < maxCycles);
    if (done == 2'b00) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
      idx = -1;
    end else begin
      checkOutput("done_onehot", 32'($countones(done)), 32'd1);
      idx = done[1] ? 1 : 0;
    end
  endtask

  initial begin
    int idx;
    int s0, d0, d1;

    // Reset with both requests asserted.
    applyStimulus(2'b11, 8'h00, 8'h00, 8'h00, 8'h00);
    Reset_n = 1'b0;
    repeat (2) @(negedge Clock);
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_start", 32'(core_start), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_prod0", 32'(product0), 32'd0);
    checkOutput("rst_prod1", 32'(product1), 32'd0);
    checkOutput("rst_mplier", 32'(core_mplier), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    applyStimulus(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Single request: 3 * -2 = -6.
    s0 = startCount;
    applyStimulus(2'b01, 8'h03, 8'hFE, 8'h00, 8'h00);
    waitStart("single", 8'h03, 8'hFE);
    checkOutput("single_gnt", 32'(gnt), 32'd1);
    waitDone(40, idx);
    checkOutput("single_owner", 32'(idx), 32'd0);
    checkOutput("single_prod0", 32'(product0), 32'h0000FFFA);
    applyStimulus(2'b00, 8'h03, 8'hFE, 8'h00, 8'h00);
    @(negedge Clock);
    checkOutput("single_gnt_clear", 32'(gnt), 32'd0);
    checkOutput("single_done_clear", 32'(done), 32'd0);
    checkOutput("single_starts", 32'(startCount - s0), 32'd1);

    // Contention from reset: order 0,1,0 with one idle cycle between jobs.
    Reset_n = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;
    s0 = startCount;
    d0 = done0Count;
    d1 = done1Count;
    applyStimulus(2'b11, 8'h05, 8'h07, 8'h80, 8'h80);
    waitDone(40, idx);
    checkOutput("cont_first", 32'(idx), 32'd0);
    checkOutput("cont_prod0", 32'(product0), 32'h00000023);
    @(negedge Clock);
    checkOutput("cont_gap_gnt", 32'(gnt), 32'd0);
    @(negedge Clock);
    checkOutput("cont_second_gnt", 32'(gnt), 32'd2);
    waitDone(40, idx);
    checkOutput("cont_second", 32'(idx), 32'd1);
    checkOutput("cont_prod1", 32'(product1), 32'h00004000);
    waitDone(40, idx);
    checkOutput("cont_third", 32'(idx), 32'd0);
    applyStimulus(2'b00, 8'h05, 8'h07, 8'h80, 8'h80);
    @(negedge Clock);
    checkOutput("cont_done0_count", 32'(done0Count - d0), 32'd2);
    checkOutput("cont_done1_count", 32'(done1Count - d1), 32'd1);
    checkOutput("cont_starts", 32'(startCount - s0), 32'd3);

    // Stale Done from the previous job lingers for a few cycles after the load.
    checkOutput("sticky_pre", 32'(core_done), 32'd1);
    stickyHold = 4;
    applyStimulus(2'b01, 8'hFF, 8'h02, 8'h80, 8'h80);
    waitStart("sticky", 8'hFF, 8'h02);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      checkOutput("sticky_hold_done", 32'(done), 32'd0);
      checkOutput("sticky_hold_busy", 32'(busy), 32'd1);
      checkOutput("sticky_hold_prod0", 32'(product0), 32'h00000023);
    end
    waitDone(40, idx);
    checkOutput("sticky_owner", 32'(idx), 32'd0);
    checkOutput("sticky_prod0", 32'(product0), 32'h0000FFFE);
    applyStimulus(2'b00, 8'hFF, 8'h02, 8'h80, 8'h80);
    stickyHold = 0;
    @(negedge Clock);

    // Reset while waiting on a slow core, then a fresh request from port 1.
    coreLatency = 10;
    applyStimulus(2'b01, 8'h02, 8'h03, 8'h80, 8'h80);
    waitStart("rstwait", 8'h02, 8'h03);
    repeat (3) @(negedge Clock);
    checkOutput("rstwait_busy_pre", 32'(busy), 32'd1);
    d0 = done0Count;
    Reset_n = 1'b0;
    applyStimulus(2'b00, 8'h02, 8'h03, 8'h80, 8'h80);
    #1;
    checkOutput("rstwait_busy", 32'(busy), 32'd0);
    checkOutput("rstwait_gnt", 32'(gnt), 32'd0);
    checkOutput("rstwait_done", 32'(done), 32'd0);
    checkOutput("rstwait_prod0", 32'(product0), 32'd0);
    repeat (3) @(negedge Clock);
    checkOutput("rstwait_no_done", 32'(done0Count - d0), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clock);
    coreLatency = 3;
    applyStimulus(2'b10, 8'h02, 8'h03, 8'hF0, 8'h04);
    waitStart("fresh", 8'hF0, 8'h04);
    waitDone(40, idx);
    checkOutput("fresh_owner", 32'(idx), 32'd1);
    checkOutput("fresh_prod1", 32'(product1), 32'h0000FFC0);
    checkOutput("fresh_prod0", 32'(product0), 32'd0);
    applyStimulus(2'b00, 8'h02, 8'h03, 8'hF0, 8'h04);
    @(negedge Clock);

`ifdef BOOTH_ARB_TIMEOUT_EN
    // Core never finishes: abort after 32 cycles, then serve the other port.
    stuckCore = 1'b1;
    applyStimulus(2'b11, 8'h02, 8'h03, 8'h7F, 8'h7F);
    waitStart("tmo", 8'h02, 8'h03);
    checkOutput("tmo_err_pre", 32'(err), 32'd0);
    waitDone(60, idx);
    checkOutput("tmo_owner", 32'(idx), 32'd0);
    checkOutput("tmo_err", 32'(err), 32'd1);
    checkOutput("tmo_prod0", 32'(product0), 32'd0);
    stuckCore = 1'b0;
    applyStimulus(2'b10, 8'h02, 8'h03, 8'h7F, 8'h7F);
    waitDone(40, idx);
    checkOutput("tmo_next_owner", 32'(idx), 32'd1);
    checkOutput("tmo_next_prod1", 32'(product1), 32'h00003F01);
    checkOutput("tmo_err_sticky", 32'(err), 32'd1);
    applyStimulus(2'b00, 8'h02, 8'h03, 8'h7F, 8'h7F);
    @(negedge Clock);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
